// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave exposing NUM_REGS registers of DATA_W bits.
// A command byte (op[7:6], start address[5:0]) selects read, write, bit-set
// or bit-clear; data words follow MSB first with burst auto-increment.
// All SPI pins are oversampled and synchronised into the clk domain.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   spi_clk     SCK (idle low), spi_ss chip select (active low), spi_mosi data in
//   spi_miso    readback data, MSB first; 0 outside the data phase
//   reg_out     flattened registers, register i at [i*DATA_W +: DATA_W]
//   wr_pulse    one-cycle strobe per committed word; wr_addr its address
//   frame_err   sticky: unmapped write/set/clear or frame aborted mid-word
module spi_reg_bank #(
  parameter int unsigned       NUM_REGS  = 4,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_clk,
  input  logic                         spi_ss,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         wr_pulse,
  output logic [5:0]                   wr_addr,
  output logic                         frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01,
                            OP_SET  = 2'b10, OP_CLR   = 2'b11} op_e;

  // Synchronisers; sck has a third stage used only as the edge-detect history.
  logic [2:0] sck_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its predecessor, which is what turns these into real shift chains.
      sck_sync_q  <= {sck_sync_q[1:0], spi_clk};
      ss_sync_q   <= {ss_sync_q[0], spi_ss};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  logic sck_rise, sck_fall, ss_s, mosi_s;
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_s     = ss_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [5:0]         addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [DATA_W-1:0]  miso_sr_q, miso_sr_d;
  logic               done_q, done_d;
  logic               wr_pulse_q, wr_pulse_d;
  logic [5:0]         wr_addr_q, wr_addr_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];

  logic [5:0]         next_addr, snap_addr;
  logic [DATA_W-1:0]  snap_val, cur_val, new_val;
  logic               mapped, last_bit;

  assign next_addr = (addr_q == 6'(NUM_REGS - 1)) ? 6'd0 : addr_q + 6'd1;
  assign mapped    = ({1'b0, addr_q} < 7'(NUM_REGS));
  // The command byte occupies the low 8 bits of the shared shift register.
  assign snap_addr = (state_q == ST_CMD) ? sr_q[5:0] : next_addr;
  assign last_bit  = (state_q == ST_CMD) ? (cnt_q == CNT_W'(7))
                                         : (cnt_q == CNT_W'(DATA_W - 1));

  // Address decode by comparison, so unmapped addresses simply read as 0.
  always_comb begin
    snap_val = '0;
    cur_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (snap_addr == 6'(i)) snap_val = regs_q[i];
      if (addr_q == 6'(i))    cur_val  = regs_q[i];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    miso_sr_d  = miso_sr_q;
    done_d     = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    err_d      = err_q;
    regs_d     = regs_q;
    new_val    = '0;

    case (op_q)
      OP_WRITE: new_val = sr_q;
      OP_SET:   new_val = cur_val | sr_q;
      default:  new_val = cur_val & ~sr_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!ss_s) begin
          state_d   = ST_CMD;
          cnt_d     = '0;
          miso_sr_d = '0;
        end
      end
      default: begin
        if (ss_s) begin
          // A non-zero bit count means a byte or word was cut short.
          if (cnt_q != '0) err_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
          miso_sr_d = '0;
        end else if (done_q) begin
          // Word/command completion is handled one cycle after the last bit.
          miso_sr_d = snap_val;
          if (state_q == ST_CMD) begin
            op_d    = op_e'(sr_q[7:6]);
            addr_d  = sr_q[5:0];
            state_d = ST_DATA;
          end else begin
            if (op_q != OP_READ) begin
              if (mapped) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == 6'(i)) regs_d[i] = new_val;
                end
                wr_pulse_d = 1'b1;
                wr_addr_d  = addr_q;
              end else begin
                err_d = 1'b1;
              end
            end
            addr_d = next_addr;
          end
        end else if (sck_rise) begin
          sr_d = {sr_q[DATA_W-2:0], mosi_s};
          if (last_bit) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sck_fall && cnt_q != '0) begin
          // The falling edge right after a word boundary is skipped so the
          // freshly loaded MSB stays on MISO for the first data bit.
          miso_sr_d = {miso_sr_q[DATA_W-2:0], 1'b0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      miso_sr_q  <= '0;
      done_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
      // NOTE: this array is a set of configuration flops, not a RAM, so it is
      // reset like any other register to guarantee defined outputs.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      miso_sr_q  <= miso_sr_d;
      done_q     <= done_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign spi_miso  = (state_q == ST_DATA) & miso_sr_q[DATA_W-1];
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Testbench for spi_reg_bank (NUM_REGS=4, DATA_W=16, RESET_VAL=16'h1234).
// A behavioural register-bank model predicts register contents, commits,
// readback words and the error flag; a per-cycle compare process checks the
// DUT against it, and directed scenarios pin the model with literal values.
module tb_spi_reg_bank;

  localparam int          NR   = 4;
  localparam int          DW   = 16;
  localparam logic [15:0] RV   = 16'h1234;
  localparam int          HALF = 5;   // SCK half-period in clk cycles

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              spi_clk  = 1'b0;
  logic              spi_ss   = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [NR*DW-1:0]  reg_out;
  logic              wr_pulse;
  logic [5:0]        wr_addr;
  logic              frame_err;

  spi_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_ss    (spi_ss),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_out   (reg_out),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_regs [NR];
  logic        m_err;
  logic [5:0]  exp_q [$];
  int          pulses_since_reset;
  bit          settled  = 1'b0;
  bit          ss_quiet = 1'b0;
  logic [15:0] tx_q [$];
  logic [15:0] rx_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NR; i++) f[i*16 +: 16] = m_regs[i];
    return f;
  endfunction

  // Compare process: reset values while reset is held, commit strobes always,
  // register file and error flag whenever no frame is in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_reg_out", reg_out, {4{RV}});
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_miso", spi_miso, 1'b0);
      check("rst_wr_pulse", wr_pulse, 1'b0);
      check("rst_wr_addr", wr_addr, 6'd0);
    end else begin
      if (wr_pulse) begin
        pulses_since_reset++;
        if (exp_q.size() == 0) check("wr_pulse_unexpected", wr_pulse, 1'b0);
        else                   check("wr_addr", wr_addr, exp_q.pop_front());
      end
      if (settled) begin
        check("reg_out", reg_out, model_flat());
        check("frame_err", frame_err, m_err);
      end
      if (ss_quiet) check("miso_idle", spi_miso, 1'b0);
    end
  end

  task automatic half_period();
    repeat (HALF) @(posedge clk);
    #2;
  endtask

  // Mode-0 host: set MOSI while SCK low, sample MISO just before rising edge.
  task automatic xfer(input int nbits, input logic [15:0] tx, output logic [15:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      half_period();
      rx = {rx[14:0], spi_miso};
      spi_clk = 1'b1;
      half_period();
      spi_clk = 1'b0;
    end
  endtask

  task automatic do_reset();
    settled  = 1'b0;
    ss_quiet = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
    m_err = 1'b0;
    exp_q.delete();
    pulses_since_reset = 0;
    repeat (3) @(posedge clk);
    #2;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_ss   = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    settled  = 1'b1;
    ss_quiet = 1'b1;
  endtask

  // One frame: command byte, the words queued in tx_q, then optionally a
  // partial word of extra_bits bits before ss is raised.
  task automatic run_frame(input logic [7:0] cmd, input int extra_bits, input logic [15:0] extra_val);
    logic [15:0] rx, d, want_rd;
    logic [1:0]  op;
    logic [5:0]  addr;
    op   = cmd[7:6];
    addr = cmd[5:0];
    settled  = 1'b0;
    ss_quiet = 1'b0;
    rx_q.delete();
    spi_ss = 1'b0;
    half_period();
    xfer(8, {8'h00, cmd}, rx);
    check("miso_cmd_byte", rx, 16'h0000);
    while (tx_q.size() > 0) begin
      d       = tx_q.pop_front();
      want_rd = (int'(addr) < NR) ? m_regs[addr[1:0]] : 16'h0000;
      if (op != 2'b00) begin
        if (int'(addr) < NR) begin
          case (op)
            2'b01:   m_regs[addr[1:0]] = d;
            2'b10:   m_regs[addr[1:0]] = m_regs[addr[1:0]] | d;
            default: m_regs[addr[1:0]] = m_regs[addr[1:0]] & ~d;
          endcase
          exp_q.push_back(addr);
        end else begin
          m_err = 1'b1;
        end
      end
      xfer(16, d, rx);
      rx_q.push_back(rx);
      if (op == 2'b00) check("miso_read", rx, want_rd);
      addr = (int'(addr) == NR - 1) ? 6'd0 : addr + 6'd1;
    end
    if (extra_bits > 0) begin
      xfer(extra_bits, extra_val, rx);
      m_err = 1'b1;
    end
    repeat (2) @(posedge clk);
    #2;
    spi_ss = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    settled  = 1'b1;
    ss_quiet = 1'b1;
    check("pulses_pending", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] rx;
    logic [1:0]  op;
    logic [5:0]  a;
    int          nw, eb;

    #1;
    do_reset();

    // Burst write with wrap: reg3 then reg0.
    tx_q = '{16'hBEEF, 16'hCAFE};
    run_frame(8'h43, 0, 16'h0);
    check("burst_reg3", reg_out[3*16 +: 16], 16'hBEEF);
    check("burst_reg0", reg_out[0 +: 16], 16'hCAFE);
    check("burst_wr_addr_last", wr_addr, 6'd0);

    // Set then clear on reg1.
    tx_q = '{16'h00F0};
    run_frame(8'h41, 0, 16'h0);
    tx_q = '{16'h0F01};
    run_frame(8'h81, 0, 16'h0);
    check("set_reg1", reg_out[1*16 +: 16], 16'h0FF1);
    tx_q = '{16'h00F0};
    run_frame(8'hC1, 0, 16'h0);
    check("clr_reg1", reg_out[1*16 +: 16], 16'h0F01);

    // Read burst from reg2.
    tx_q = '{16'hA5A5, 16'h0102};
    run_frame(8'h42, 0, 16'h0);
    tx_q = '{16'h0000, 16'h0000};
    run_frame(8'h02, 0, 16'h0);
    check("read_word0", rx_q[0], 16'hA5A5);
    check("read_word1", rx_q[1], 16'h0102);

    // Unmapped write.
    tx_q = '{16'h1111};
    run_frame(8'h45, 0, 16'h0);
    check("unmapped_err", frame_err, 1'b1);

    // Frame aborted after one data byte.
    do_reset();
    run_frame(8'h41, 8, 16'h00AB);
    check("abort_reg1", reg_out[1*16 +: 16], 16'h1234);
    check("abort_err", frame_err, 1'b1);

    // Randomised frames against the model.
    for (int f = 0; f < 30; f++) begin
      if (f % 10 == 0) do_reset();
      op = 2'($urandom_range(3, 0));
      a  = 6'($urandom_range(5, 0));
      nw = $urandom_range(3, 0);
      for (int w = 0; w < nw; w++) tx_q.push_back(16'($urandom));
      eb = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 1) : 0;
      run_frame({op, a}, eb, 16'($urandom));
    end

    // Reset in the middle of a frame, then a clean write.
    settled  = 1'b0;
    ss_quiet = 1'b0;
    spi_ss   = 1'b0;
    half_period();
    xfer(8, 16'h0040, rx);
    xfer(4, 16'h000F, rx);
    do_reset();
    tx_q = '{16'h0007};
    run_frame(8'h40, 0, 16'h0);
    check("post_reset_reg0", reg_out[0 +: 16], 16'h0007);
    check("post_reset_pulses", pulses_since_reset, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
